// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, LSB-first data, stop bit(s) over a
// valid/ready handshake. All outputs are registered from next-state values.
module serial_tx #(
  parameter int P_DATA_W       = 8,
  parameter int P_CLKS_PER_BIT = 16,
  parameter int P_STOP_BITS    = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [P_DATA_W-1:0] i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_sgnl,
  output logic                o_busy,
  output logic                o_done
);

  localparam int BAUD_W = $clog2(P_CLKS_PER_BIT) + 1;
  localparam int BIT_W  = $clog2(P_DATA_W) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(P_CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(P_DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(P_STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t              state, state_nxt;
  logic [BAUD_W-1:0]   baud_cnt, baud_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic [P_DATA_W-1:0] shift, shift_nxt;
  logic                sgnl_nxt;
  logic                done_nxt;
  logic                bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (i_valid) begin
          shift_nxt = i_data;
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_cnt == DATA_LAST) begin
            bit_nxt   = '0;
            state_nxt = STOP;
          end else begin
            bit_nxt   = bit_cnt + BIT_W'(1);
            shift_nxt = shift >> 1;
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        // bit_cnt is reused here to count stop bits
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_nxt   = '0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      START:   sgnl_nxt = 1'b0;
      DATA:    sgnl_nxt = shift_nxt[0];
      default: sgnl_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      o_sgnl   <= 1'b1;
      o_ready  <= 1'b1;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      o_sgnl   <= sgnl_nxt;
      o_ready  <= (state_nxt == IDLE);
      o_busy   <= (state_nxt != IDLE);
      o_done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: a line monitor decodes frames against a queue of
// accepted words; a second instance covers two stop bits at one clock per bit.
module tb_serial_tx;

  localparam int W = 8;
  localparam int C = 4;
  localparam int N = 1 + W + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [W-1:0] data_a = '0;
  logic         valid_a = 1'b0;
  logic         ready_a, sgnl_a, busy_a, done_a;

  logic [W-1:0] data_b = '0;
  logic         valid_b = 1'b0;
  logic         ready_b, sgnl_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [N-1:0] m_exp;
  logic         m_active = 1'b0;
  int           m_cnt = 0;
  int           frames_a = 0;
  int           last_done_cyc = 0;
  int           m_gap = 0;
  int           k_acc = 0;

  serial_tx #(.P_DATA_W(W), .P_CLKS_PER_BIT(C), .P_STOP_BITS(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_data(data_a), .i_valid(valid_a),
    .o_ready(ready_a), .o_sgnl(sgnl_a), .o_busy(busy_a), .o_done(done_a)
  );

  serial_tx #(.P_DATA_W(W), .P_CLKS_PER_BIT(1), .P_STOP_BITS(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_data(data_b), .i_valid(valid_b),
    .o_ready(ready_b), .o_sgnl(sgnl_b), .o_busy(busy_b), .o_done(done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Receiver model for dut_a: every clock of a frame is checked against the
  // bit the popped word implies, then the completion cycle.
  always @(negedge clk) begin
    if (!rst) begin
      m_active = 1'b0;
      check("rst_sgnl", sgnl_a, 1);
      check("rst_ready", ready_a, 1);
      check("rst_done", done_a, 0);
    end else begin
      if (!m_active && sgnl_a == 1'b0) begin
        check("queued_frame", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          m_exp    = {1'b1, exp_q.pop_front(), 1'b0};
          m_active = 1'b1;
          m_cnt    = 0;
          m_gap    = cyc - last_done_cyc;
        end
      end
      if (m_active) begin
        if (m_cnt == N * C) begin
          check("done_pulse", done_a, 1);
          check("done_ready", ready_a, 1);
          check("done_busy", busy_a, 0);
          check("done_sgnl", sgnl_a, 1);
          m_active      = 1'b0;
          frames_a++;
          last_done_cyc = cyc;
        end else begin
          check("line_bit", sgnl_a, m_exp[m_cnt / C]);
          check("frame_ready", ready_a, 0);
          check("frame_busy", busy_a, 1);
          check("frame_done", done_a, 0);
          m_cnt++;
        end
      end else begin
        check("idle_sgnl", sgnl_a, 1);
        check("idle_ready", ready_a, 1);
        check("idle_done", done_a, 0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", ready_a, 1);
  endtask

  task automatic send(input logic [W-1:0] d);
    wait_ready();
    data_a  = d;
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(d);
    k_acc   = cyc;
    valid_a = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((m_active || exp_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", m_active || exp_q.size() != 0, 0);
  endtask

  logic [10:0] exp_b;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("init_sgnl", sgnl_a, 1);
    check("init_ready", ready_a, 1);
    check("init_busy", busy_a, 0);

    // single frame, exact timing
    send(8'hA5);
    wait_idle();
    check("a5_done_time", last_done_cyc - k_acc, N * C);
    check("a5_frames", frames_a, 1);

    // back-to-back with valid held
    wait_ready();
    data_a  = 8'h00;
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(8'h00);
    data_a = 8'hFF;
    wait_ready();
    @(posedge clk);
    #1;
    exp_q.push_back(8'hFF);
    valid_a = 1'b0;
    wait_idle();
    check("b2b_gap", m_gap, 1);
    check("b2b_frames", frames_a, 3);

    // valid pulses during a frame are ignored
    send(8'h5A);
    for (int i = 0; i < 3; i++) begin
      repeat (8) @(posedge clk);
      #1;
      data_a  = 8'h12;
      valid_a = 1'b1;
      @(posedge clk);
      #1;
      valid_a = 1'b0;
    end
    wait_idle();
    repeat (50) @(negedge clk);
    check("ignore_frames", frames_a, 4);

    // reset mid-DATA drops the frame
    send(8'hC3);
    repeat (17) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_sgnl", sgnl_a, 1);
    check("midrst_ready", ready_a, 1);
    check("midrst_busy", busy_a, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("midrst_frames", frames_a, 4);
    send(8'h81);
    wait_idle();
    check("post_rst_frames", frames_a, 5);

    // two stop bits, one clock per bit
    exp_b = 11'b110_0111_1000;
    @(negedge clk);
    check("b_ready", ready_b, 1);
    data_b  = 8'h3C;
    valid_b = 1'b1;
    @(posedge clk);
    #1;
    valid_b = 1'b0;
    k_acc   = cyc;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check("b_line", sgnl_b, exp_b[i]);
      check("b_done_low", done_b, 0);
    end
    @(negedge clk);
    check("b_done", done_b, 1);
    check("b_done_time", cyc - k_acc, 11);
    check("b_ready_end", ready_b, 1);
    @(negedge clk);
    check("b_done_once", done_b, 0);

    // long idle after reset
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle100_sgnl_a", sgnl_a, 1);
      check("idle100_done_a", done_a, 0);
      check("idle100_sgnl_b", sgnl_b, 1);
      check("idle100_ready_b", ready_b, 1);
      check("idle100_done_b", done_b, 0);
    end

    check("queue_empty", exp_q.size(), 0);
    check("total_frames", frames_a, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
